// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the fetch/execute/writeback pipeline.
// Produces forwarding selects, stall/flush controls and next-PC select, holds
// the pipe across slow loads (with a bus-error timeout) and owns trap state.
module pipeline_hazard_ctrl #(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_ex,
  input  logic [4:0]  rs2_ex,
  input  logic [4:0]  rd_wb,
  input  logic        reg_wr_wb,
  input  logic        is_load_wb,
  input  logic        dmem_ready,
  input  logic        valid_ex,
  input  logic [31:0] pc_ex,
  input  logic        br_taken_ex,
  input  logic [31:0] br_target_ex,
  input  logic        mret_ex,
  input  logic        irq,
  input  logic        irq_en,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        stall_if,
  output logic        stall_id_ex,
  output logic        stall_ex_wb,
  output logic        flush_id_ex,
  output logic [1:0]  pc_sel,
  output logic [31:0] trap_vec,
  output logic [31:0] epc,
  output logic        trap_take,
  output logic        bus_err,
  output logic        in_handler,
  output logic [31:0] stall_cnt
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  typedef enum logic {RUN, LOAD_WAIT} state_t;

  state_t      state, state_nx;
  logic [7:0]  wait_cnt, wait_cnt_nx;
  logic [31:0] epc_nx;
  logic        in_handler_nx;
  logic        mem_wait, timeout, stall;

  assign trap_vec    = TRAP_VEC;
  assign stall_if    = stall;
  assign stall_id_ex = stall;
  assign stall_ex_wb = stall;

  // Decode controls and next state; reset forces every control low.
  always_comb begin
    fwd_a         = 1'b0;
    fwd_b         = 1'b0;
    stall         = 1'b0;
    flush_id_ex   = 1'b0;
    pc_sel        = 2'b00;
    trap_take     = 1'b0;
    bus_err       = 1'b0;
    state_nx      = state;
    wait_cnt_nx   = wait_cnt;
    epc_nx        = epc;
    in_handler_nx = in_handler;
    // In LOAD_WAIT only dmem_ready matters; in RUN a fresh load must be pending.
    mem_wait = (state == LOAD_WAIT) ? ~dmem_ready : (is_load_wb & ~dmem_ready);
    timeout  = (state == LOAD_WAIT) & ~dmem_ready & (wait_cnt == TMO);
    if (rst) begin
      state_nx      = RUN;
      wait_cnt_nx   = 8'd0;
      epc_nx        = 32'd0;
      in_handler_nx = 1'b0;
    end else if (timeout) begin
      // Load never returned: abandon it and trap, even from inside a handler.
      bus_err       = 1'b1;
      trap_take     = 1'b1;
      pc_sel        = 2'b10;
      flush_id_ex   = 1'b1;
      epc_nx        = pc_ex;
      in_handler_nx = 1'b1;
      state_nx      = RUN;
      wait_cnt_nx   = 8'd0;
    end else if (mem_wait) begin
      // Freeze the whole pipe; branches and irqs are re-evaluated on release.
      stall       = 1'b1;
      state_nx    = LOAD_WAIT;
      wait_cnt_nx = (state == RUN) ? 8'd1 : wait_cnt + 8'd1;
    end else begin
      state_nx    = RUN;
      wait_cnt_nx = 8'd0;
      fwd_a = reg_wr_wb & (rd_wb != 5'd0) & (rd_wb == rs1_ex);
      fwd_b = reg_wr_wb & (rd_wb != 5'd0) & (rd_wb == rs2_ex);
      if (irq & irq_en & ~in_handler & valid_ex & ~mret_ex) begin
        // Execute instruction commits, so return to its successor.
        trap_take     = 1'b1;
        pc_sel        = 2'b10;
        flush_id_ex   = 1'b1;
        epc_nx        = br_taken_ex ? br_target_ex : pc_ex + 32'd4;
        in_handler_nx = 1'b1;
      end else if (mret_ex & valid_ex) begin
        pc_sel        = 2'b11;
        flush_id_ex   = 1'b1;
        in_handler_nx = 1'b0;
      end else if (br_taken_ex & valid_ex) begin
        pc_sel      = 2'b01;
        flush_id_ex = 1'b1;
      end
    end
  end

  // State, trap registers and saturating stall counter.
  always_ff @(posedge clk) begin
    state      <= state_nx;
    wait_cnt   <= wait_cnt_nx;
    epc        <= epc_nx;
    in_handler <= in_handler_nx;
    if (rst)
      stall_cnt <= 32'd0;
    else if (stall && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a behavioural model predicts each
// cycle's controls, pushes them to a queue, and they are popped and compared
// mid-cycle against the DUT.
module tb_pipeline_hazard_ctrl;
  localparam int          TMO = 4;
  localparam logic [31:0] TV  = 32'h0000_0100;

  logic clk = 1'b0, rst = 1'b1;
  logic [4:0]  rs1_ex, rs2_ex, rd_wb;
  logic        reg_wr_wb, is_load_wb, dmem_ready, valid_ex, br_taken_ex;
  logic        mret_ex, irq, irq_en;
  logic [31:0] pc_ex, br_target_ex;
  logic        fwd_a, fwd_b, stall_if, stall_id_ex, stall_ex_wb, flush_id_ex;
  logic [1:0]  pc_sel;
  logic [31:0] trap_vec, epc, stall_cnt;
  logic        trap_take, bus_err, in_handler;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .TRAP_VEC(TV)) dut (
    .clk(clk), .rst(rst), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_wb(rd_wb),
    .reg_wr_wb(reg_wr_wb), .is_load_wb(is_load_wb), .dmem_ready(dmem_ready),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .br_taken_ex(br_taken_ex),
    .br_target_ex(br_target_ex), .mret_ex(mret_ex), .irq(irq), .irq_en(irq_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if), .stall_id_ex(stall_id_ex),
    .stall_ex_wb(stall_ex_wb), .flush_id_ex(flush_id_ex), .pc_sel(pc_sel),
    .trap_vec(trap_vec), .epc(epc), .trap_take(trap_take), .bus_err(bus_err),
    .in_handler(in_handler), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic fa, fb, st, fl;
    logic [1:0] ps;
    logic tt, be;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_err = 0;

  // reference model state
  logic        m_lw = 1'b0, m_inh = 1'b0;
  int          m_wc = 0;
  logic [31:0] m_epc = '0, m_cnt = '0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle();
    rs1_ex = '0; rs2_ex = '0; rd_wb = '0; reg_wr_wb = 0; is_load_wb = 0;
    dmem_ready = 0; valid_ex = 0; pc_ex = '0; br_taken_ex = 0;
    br_target_ex = '0; mret_ex = 0; irq = 0; irq_en = 0;
  endtask

  function automatic logic tmo_now();
    return m_lw && !dmem_ready && (m_wc == TMO);
  endfunction

  function automatic logic held_now();
    return (m_lw || is_load_wb) && !dmem_ready;
  endfunction

  function automatic logic irq_now();
    return irq && irq_en && !m_inh && valid_ex && !mret_ex;
  endfunction

  function automatic exp_t predict();
    exp_t e = '0;
    if (rst) return e;
    if (tmo_now()) begin
      e.be = 1; e.tt = 1; e.ps = 2'b10; e.fl = 1;
    end else if (held_now()) begin
      e.st = 1;
    end else begin
      e.fa = reg_wr_wb && rd_wb != 0 && rd_wb == rs1_ex;
      e.fb = reg_wr_wb && rd_wb != 0 && rd_wb == rs2_ex;
      if (irq_now())                    begin e.tt = 1; e.ps = 2'b10; e.fl = 1; end
      else if (mret_ex && valid_ex)     begin e.ps = 2'b11; e.fl = 1; end
      else if (br_taken_ex && valid_ex) begin e.ps = 2'b01; e.fl = 1; end
    end
    return e;
  endfunction

  task automatic advance(exp_t e);
    if (rst) begin
      m_lw = 0; m_wc = 0; m_epc = '0; m_inh = 0; m_cnt = '0;
      return;
    end
    if (e.st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (tmo_now()) begin
      m_epc = pc_ex; m_inh = 1; m_lw = 0; m_wc = 0;
    end else if (held_now()) begin
      m_wc = m_lw ? m_wc + 1 : 1;
      m_lw = 1;
    end else begin
      m_lw = 0; m_wc = 0;
      if (irq_now()) begin
        m_epc = br_taken_ex ? br_target_ex : pc_ex + 32'd4;
        m_inh = 1;
      end else if (mret_ex && valid_ex) m_inh = 0;
    end
  endtask

  // one clock: inputs already driven; predict, compare mid-cycle, clock model
  task automatic step();
    exp_t e;
    q.push_back(predict());
    @(negedge clk);
    e = q.pop_front();
    chk("fwd_a", 32'(fwd_a), 32'(e.fa));
    chk("fwd_b", 32'(fwd_b), 32'(e.fb));
    chk("stall_if", 32'(stall_if), 32'(e.st));
    chk("stall_id_ex", 32'(stall_id_ex), 32'(e.st));
    chk("stall_ex_wb", 32'(stall_ex_wb), 32'(e.st));
    chk("flush", 32'(flush_id_ex), 32'(e.fl));
    chk("pc_sel", 32'(pc_sel), 32'(e.ps));
    chk("trap_take", 32'(trap_take), 32'(e.tt));
    chk("bus_err", 32'(bus_err), 32'(e.be));
    chk("trap_vec", trap_vec, TV);
    chk("epc", epc, m_epc);
    chk("in_handler", 32'(in_handler), 32'(m_inh));
    chk("stall_cnt", stall_cnt, m_cnt);
    @(posedge clk);
    advance(e);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    step(); step();
    rst = 0;

    // forwarding: hit on A, zero register never forwards, hit on B
    rd_wb = 5; reg_wr_wb = 1; rs1_ex = 5; rs2_ex = 0; step();
    rd_wb = 0; rs1_ex = 0; step();
    rd_wb = 7; rs1_ex = 3; rs2_ex = 7; step();
    reg_wr_wb = 0; step();
    idle();

    // load held 3 cycles then ready; forwarding only on the ready cycle
    is_load_wb = 1; reg_wr_wb = 1; rd_wb = 9; rs1_ex = 9;
    repeat (3) step();
    dmem_ready = 1; step();
    idle(); step();
    chk("stall_cnt_3", stall_cnt, 32'd3);

    // taken branch, then branch with simultaneous irq
    valid_ex = 1; br_taken_ex = 1; br_target_ex = 32'h40; pc_ex = 32'h10; step();
    irq = 1; irq_en = 1; step();
    idle(); step();
    chk("epc_br_irq", epc, 32'h40);
    valid_ex = 1; mret_ex = 1; step();
    idle();

    // irq at 0x20, second irq ignored in handler, mret
    valid_ex = 1; pc_ex = 32'h20; irq = 1; irq_en = 1; step();
    step();
    chk("epc_irq", epc, 32'h24);
    irq = 0; mret_ex = 1; step();
    idle(); step();

    // pc+4 wraps
    valid_ex = 1; pc_ex = 32'hFFFF_FFFC; irq = 1; irq_en = 1; step();
    idle(); valid_ex = 1; mret_ex = 1; step();
    idle();

    // load timeout: bus error on 5th held cycle
    is_load_wb = 1; valid_ex = 1; pc_ex = 32'h80;
    repeat (5) step();
    idle(); step();
    chk("epc_buserr", epc, 32'h80);
    valid_ex = 1; mret_ex = 1; step();
    idle();

    // reset mid LOAD_WAIT, then the pending load re-stalls
    is_load_wb = 1;
    repeat (2) step();
    rst = 1; step();
    rst = 0; step(); step();
    dmem_ready = 1; step();
    idle();

    // constrained random traffic
    for (int i = 0; i < 80; i++) begin
      rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
      rd_wb = 5'($urandom_range(0, 3)); reg_wr_wb = 1'($urandom_range(0, 1));
      is_load_wb = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      valid_ex = ($urandom_range(0, 4) != 0);
      pc_ex = {$urandom_range(0, 255), 2'b00} ;
      br_taken_ex = ($urandom_range(0, 3) == 0);
      br_target_ex = {$urandom_range(0, 255), 2'b00};
      mret_ex = ($urandom_range(0, 7) == 0);
      irq = ($urandom_range(0, 5) == 0); irq_en = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
